// File: rtl/demux_8_reg.sv
// demux_8_reg: steers one producer word per cycle into one of eight single-entry output slots
module demux_8_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] in_data,
  output logic [7:0]       out_valid,
  input  logic [7:0]       out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [3:0]       occupancy
);
  logic [WIDTH-1:0] r_data [8];
  logic [7:0]       r_full;
  logic [3:0]       r_occ;
  logic             w_acc;
  logic [7:0]       w_wr;
  logic [7:0]       w_drain;
  logic [7:0]       w_full_nxt;
  logic [3:0]       w_cnt;

  // A slot can take a word if it is empty or its consumer is draining it this cycle
  assign in_ready  = ~r_full[select] | out_ready[select];
  assign w_acc     = in_valid & in_ready;
  assign w_wr      = w_acc ? (8'd1 << select) : 8'd0;
  assign w_drain   = r_full & out_ready;
  assign w_full_nxt = (r_full & ~w_drain) | w_wr;

  // Post-edge occupancy is the popcount of the next full vector, so it tracks out_valid exactly
  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < 8; i++) w_cnt = w_cnt + {3'd0, w_full_nxt[i]};
  end

  // Slot flags and occupancy; a write wins over a drain on the same slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_full <= 8'd0;
      r_occ  <= 4'd0;
    end else begin
      r_full <= w_full_nxt;
      r_occ  <= w_cnt;
    end
  end

  // Slot data registers; a drained slot keeps its last word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (w_wr[i]) r_data[i] <= in_data;
    end
  end

  assign out_valid = r_full;
  assign occupancy = r_occ;
  assign out0 = r_data[0];
  assign out1 = r_data[1];
  assign out2 = r_data[2];
  assign out3 = r_data[3];
  assign out4 = r_data[4];
  assign out5 = r_data[5];
  assign out6 = r_data[6];
  assign out7 = r_data[7];
endmodule
